// File: rtl/display_7seg_scan.sv
// Binary-to-BCD (sequential double dabble) plus 3-digit multiplexed common-anode 7-segment driver.
// Optional leading-zero blanking is enabled by defining DISP7_LZ_BLANK_EN.
module display_7seg_scan #(
  parameter int unsigned REFRESH_DIV = 10000
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [7:0] value_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    val_q, val_d;
  logic [19:0]   sh_q, sh_d;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [19:0]   adj;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM: one add-3/shift iteration per cycle over the {bcd, binary} register
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    adj     = sh_q;
    case (state_q)
      IDLE: begin
        if (value_i != val_q) begin
          val_d   = value_i;
          sh_d    = {12'd0, value_i};
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (adj[8 + 4*i +: 4] >= 4'd5) begin
            adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
          end
        end
        sh_d   = {adj[18:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = sh_q[19:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scan timing and registered anode/segment pair
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    digit = 4'd0;
    blank = 1'b0;
    an_d  = 4'b1111;
    case (idx_q)
      2'd0: begin
        digit = bcd_q[3:0];
        an_d  = 4'b1110;
      end
      2'd1: begin
        digit = bcd_q[7:4];
        an_d  = 4'b1101;
`ifdef DISP7_LZ_BLANK_EN
        blank = (bcd_q[11:4] == 8'd0);
`endif
      end
      2'd2: begin
        digit = bcd_q[11:8];
        an_d  = 4'b1011;
`ifdef DISP7_LZ_BLANK_EN
        blank = (bcd_q[11:8] == 4'd0);
`endif
      end
      default: begin
        digit = 4'd0;
        an_d  = 4'b1111;
        blank = 1'b1;
      end
    endcase
    seg_d = blank ? '1 : dec7(digit);
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      val_q   <= '0;
      sh_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sh_q    <= sh_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign busy_o = busy_q;

endmodule
